sector_write_formatter: RTL
===========================

Name: sector_write_formatter

Overview:
Upstream feeder of the MFM write serializer. On a start pulse it builds one complete data field and pushes it byte by byte into the encode FIFO:
- gap
- sync
- 3x A1 address marks
- data address mark
- sector payload read from the sector buffer
- CRC-CCITT
- trailing gap

It flags mark bytes and the final byte so the serializer can apply the missing-clock mark encoding and end the write cleanly.

Parameters:
SECTOR_BYTES, 512, payload bytes per sector (power of two, 128..1024)
GAP2_BYTES, 22, 0x4E bytes emitted before sync
SYNC_BYTES, 12, 0x00 bytes before marks
GAP3_BYTES, 54, 0x4E bytes after CRC (>=1)
GAP_BYTE, 8'h4E, gap fill value
DAM_BYTE, 8'hFB, data address mark

Ports:
clk  in  1  clock
reset_l  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin formatting (ignored while busy)
abort  in  1  one-cycle pulse; stop immediately
busy  out  1  high from cycle after start until done/abort
buf_rd_addr  out  $clog2(SECTOR_BYTES)  sector buffer read address
buf_rd_data  in  8  buffer data, valid 1 cycle after address
encode_fifo_wr_data  out  8  byte to encode FIFO
encode_fifo_wr_mark  out  1  byte is an A1 address mark (missing clock)
encode_fifo_wr_done  out  1  byte is last of the write
encode_fifo_we  out  1  write enable, one cycle per byte
encode_fifo_full  in  1  FIFO cannot accept a write this cycle

Behaviour:
- Reset is asynchronous and active-low (reset_l); clock is clk. Reset values: busy=0, encode_fifo_we=0, wr_data=0, wr_mark=0, wr_done=0, buf_rd_addr=0, state=IDLE, crc=16'hFFFF.
- Write rule: encode_fifo_we is asserted in cycle N only if encode_fifo_full=0 in cycle N. wr_data, wr_mark and wr_done are registered and qualified by we. The FIFO write itself is never stalled.
- States and transitions:
  - IDLE: on start, go to GAP2; busy=1 next cycle.
  - GAP2: emit GAP_BYTE GAP2_BYTES times.
  - SYNC: emit 0x00 SYNC_BYTES times.
  - MARK: emit 0xA1 three times with mark=1. CRC is reset to FFFF on entry and then includes all three A1s.
  - DAM: emit DAM_BYTE with mark=0; included in CRC.
  - FETCH: drive buf_rd_addr = byte index.
  - DATA: next cycle, latch buf_rd_data, emit it when not full, update CRC; index+1; return to FETCH until index reaches SECTOR_BYTES-1, then CRC_HI.
  - CRC_HI, CRC_LO: emit crc[15:8], then crc[7:0]; not included in CRC.
  - GAP3: emit GAP_BYTE GAP3_BYTES times; the last one carries done=1.
  - Then IDLE with busy=0 on the cycle after the last write.
- CRC: CRC-16-CCITT, poly 0x1021, MSB-first, init 16'hFFFF. Computed one byte per accepted write in a single cycle.
- Byte counters are sized for the maximum parameter value. Counts are exact, with no off-by-one across states.
- While the FIFO is full, the byte is held and no state or counter advances.
- start while busy: ignored.
- abort at any time: next cycle state=IDLE, busy=0, we=0, no done byte emitted. Counters and CRC are reinitialised. abort wins over a simultaneous start.
- reset_l asserted mid-operation: everything returns to reset values immediately.
- Throughput: one byte per 2 cycles worst case (FETCH/DATA), well above serializer demand.

Optional Feature:
FMT_ID_FIELD_EN
- Defined: extra inputs id_cyl[7:0], id_head[7:0], id_sec[7:0], id_size[7:0], sampled at start. Before GAP2 the block emits a full ID field: SYNC_BYTES×0x00, 3×A1 (mark=1), 0xFE, cyl, head, sec, size, then CRC over A1A1A1FE+4 bytes. The sequence then continues with GAP2 as above. This supports track formatting.
- Undefined: ports and states absent; behaviour exactly as above.

Decomposition:
- Package floppy_pkg:
  - state enum
  - A1_MARK=8'hA1, IDAM_BYTE=8'hFE, CRC_INIT=16'hFFFF, CRC_POLY=16'h1021
  - function crc16_ccitt_byte(crc, byte)
- One natural sub-module: crc16_ccitt, byte-wide with clear, enable and crc output; also reusable by the read path.

Test Plan:
- Basic sector: SECTOR_BYTES=512, buffer=0x00..0xFF repeating, FIFO never full:
  - writes 22×4E, 12×00, 3×A1 (mark=1), FB, then 512 payload bytes in order
  - then 2 CRC bytes; CRC over A1A1A1FB+payload+CRC gives residual 0x0000
  - then 54×4E with done only on the last; total 606 writes
- Backpressure: toggle encode_fifo_full pseudo-randomly at 50%. The written byte stream is identical to the basic case, and we is never asserted while full.
- Abort: abort pulse after the 100th payload write. No further we, busy=0 next cycle. A subsequent start produces a complete, correct sector.
- start during busy: a second start at write 300 has no effect; exactly 606 writes and one done.
- Reset mid-DATA: drop reset_l at an arbitrary cycle. All outputs go to reset values immediately; after release, idle until start.
- With FMT_ID_FIELD_EN, ID C=2 H=1 S=5 N=2: stream begins 12×00, A1 A1 A1 FE 02 01 05 02 with mark on the A1s only, then 2 CRC bytes with residual 0x0000, then the data field as in the basic case.

Source files
------------

// File: rtl/floppy_pkg.sv
// Shared types and CRC helper for the floppy write/read formatter datapath.
// FMT_ID_FIELD_EN adds the ID-field states used for track formatting.
package floppy_pkg;

    localparam logic [7:0]  A1_MARK   = 8'hA1;
    localparam logic [7:0]  IDAM_BYTE = 8'hFE;
    localparam logic [15:0] CRC_INIT  = 16'hFFFF;
    localparam logic [15:0] CRC_POLY  = 16'h1021;

    typedef enum logic [3:0] {
        ST_IDLE,
`ifdef FMT_ID_FIELD_EN
        ST_ID_SYNC,
        ST_ID_MARK,
        ST_IDAM,
        ST_ID_INFO,
        ST_ID_CRC_HI,
        ST_ID_CRC_LO,
`endif
        ST_GAP2,
        ST_SYNC,
        ST_MARK,
        ST_DAM,
        ST_FETCH,
        ST_DATA,
        ST_CRC_HI,
        ST_CRC_LO,
        ST_GAP3
    } state_t;

    // CRC-16-CCITT, one byte MSB-first.
    function automatic logic [15:0] crc16_ccitt_byte(input logic [15:0] crc,
                                                     input logic [7:0]  data_byte);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data_byte[i])
                c = {c[14:0], 1'b0} ^ CRC_POLY;
            else
                c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/crc16_ccitt.sv
// Byte-wide CRC-16-CCITT accumulator with synchronous clear; shared with the read path.
module crc16_ccitt
    import floppy_pkg::*;
(
    input  logic        clk,
    input  logic        reset_l,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l)
            crc <= CRC_INIT;
        else if (clr)
            crc <= CRC_INIT;
        else if (en)
            crc <= crc16_ccitt_byte(crc, data);
    end

endmodule

// File: rtl/sector_write_formatter.sv
// Builds one MFM data field (gap, sync, marks, payload, CRC, gap) into the encode FIFO.
// Define FMT_ID_FIELD_EN to prepend a full ID field for track formatting.
module sector_write_formatter
    import floppy_pkg::*;
#(
    parameter int         SECTOR_BYTES = 512,
    parameter int         GAP2_BYTES   = 22,
    parameter int         SYNC_BYTES   = 12,
    parameter int         GAP3_BYTES   = 54,
    parameter logic [7:0] GAP_BYTE     = 8'h4E,
    parameter logic [7:0] DAM_BYTE     = 8'hFB
) (
    input  logic                            clk,
    input  logic                            reset_l,
    input  logic                            start,
    input  logic                            abort,
    output logic                            busy,
`ifdef FMT_ID_FIELD_EN
    input  logic [7:0]                      id_cyl,
    input  logic [7:0]                      id_head,
    input  logic [7:0]                      id_sec,
    input  logic [7:0]                      id_size,
`endif
    output logic [$clog2(SECTOR_BYTES)-1:0] buf_rd_addr,
    input  logic [7:0]                      buf_rd_data,
    output logic [7:0]                      encode_fifo_wr_data,
    output logic                            encode_fifo_wr_mark,
    output logic                            encode_fifo_wr_done,
    output logic                            encode_fifo_we,
    input  logic                            encode_fifo_full
);

    localparam int IDX_W   = $clog2(SECTOR_BYTES);
    localparam int MAX_A   = (GAP2_BYTES > SYNC_BYTES) ? GAP2_BYTES : SYNC_BYTES;
    localparam int MAX_B   = (GAP3_BYTES > 4) ? GAP3_BYTES : 4;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic               out_vld, can_load, load, start_ok;
    logic               gen_vld, gen_mark, gen_done, gen_crc, crc_clr, crc_en;
    logic [7:0]         gen_data;
    logic [15:0]        crc;
`ifdef FMT_ID_FIELD_EN
    logic [7:0]         id_q [4];
`endif

    // The output byte register holds one pending byte; we is only raised when the FIFO has room.
    assign encode_fifo_we = out_vld & ~encode_fifo_full;
    assign can_load       = ~out_vld | encode_fifo_we;
    assign start_ok       = start & ~busy & ~abort;
    assign buf_rd_addr    = idx;

    crc16_ccitt u_crc (
        .clk     (clk),
        .reset_l (reset_l),
        .clr     (crc_clr | abort),
        .en      (crc_en),
        .data    (gen_data),
        .crc     (crc)
    );

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        gen_vld  = 1'b0;
        gen_data = 8'h00;
        gen_mark = 1'b0;
        gen_done = 1'b0;
        gen_crc  = 1'b0;
        crc_clr  = 1'b0;
        case (state)
            ST_IDLE: begin
`ifdef FMT_ID_FIELD_EN
                if (start_ok) state_n = ST_ID_SYNC;
`else
                if (start_ok) state_n = ST_GAP2;
`endif
            end
`ifdef FMT_ID_FIELD_EN
            ST_ID_SYNC: begin
                gen_vld = 1'b1;
                if (can_load) begin
                    if (cnt == CNT_W'(SYNC_BYTES - 1)) begin
                        cnt_n = '0; crc_clr = 1'b1; state_n = ST_ID_MARK;
                    end else cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_ID_MARK: begin
                gen_vld = 1'b1; gen_data = A1_MARK; gen_mark = 1'b1; gen_crc = 1'b1;
                if (can_load) begin
                    if (cnt == CNT_W'(2)) begin cnt_n = '0; state_n = ST_IDAM; end
                    else cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_IDAM: begin
                gen_vld = 1'b1; gen_data = IDAM_BYTE; gen_crc = 1'b1;
                if (can_load) state_n = ST_ID_INFO;
            end
            ST_ID_INFO: begin
                gen_vld = 1'b1; gen_data = id_q[cnt[1:0]]; gen_crc = 1'b1;
                if (can_load) begin
                    if (cnt == CNT_W'(3)) begin cnt_n = '0; state_n = ST_ID_CRC_HI; end
                    else cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_ID_CRC_HI: begin
                gen_vld = 1'b1; gen_data = crc[15:8];
                if (can_load) state_n = ST_ID_CRC_LO;
            end
            ST_ID_CRC_LO: begin
                gen_vld = 1'b1; gen_data = crc[7:0];
                if (can_load) state_n = ST_GAP2;
            end
`endif
            ST_GAP2: begin
                gen_vld = 1'b1; gen_data = GAP_BYTE;
                if (can_load) begin
                    if (cnt == CNT_W'(GAP2_BYTES - 1)) begin cnt_n = '0; state_n = ST_SYNC; end
                    else cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_SYNC: begin
                gen_vld = 1'b1;
                if (can_load) begin
                    if (cnt == CNT_W'(SYNC_BYTES - 1)) begin
                        cnt_n = '0; crc_clr = 1'b1; state_n = ST_MARK;
                    end else cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_MARK: begin
                gen_vld = 1'b1; gen_data = A1_MARK; gen_mark = 1'b1; gen_crc = 1'b1;
                if (can_load) begin
                    if (cnt == CNT_W'(2)) begin cnt_n = '0; state_n = ST_DAM; end
                    else cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_DAM: begin
                gen_vld = 1'b1; gen_data = DAM_BYTE; gen_crc = 1'b1;
                if (can_load) state_n = ST_FETCH;
            end
            // Address is presented in FETCH; the buffer answers while in DATA.
            ST_FETCH: state_n = ST_DATA;
            ST_DATA: begin
                gen_vld = 1'b1; gen_data = buf_rd_data; gen_crc = 1'b1;
                if (can_load) begin
                    if (idx == IDX_W'(SECTOR_BYTES - 1)) begin idx_n = '0; state_n = ST_CRC_HI; end
                    else begin idx_n = idx + IDX_W'(1); state_n = ST_FETCH; end
                end
            end
            ST_CRC_HI: begin
                gen_vld = 1'b1; gen_data = crc[15:8];
                if (can_load) state_n = ST_CRC_LO;
            end
            ST_CRC_LO: begin
                gen_vld = 1'b1; gen_data = crc[7:0];
                if (can_load) state_n = ST_GAP3;
            end
            ST_GAP3: begin
                gen_vld = 1'b1; gen_data = GAP_BYTE;
                gen_done = (cnt == CNT_W'(GAP3_BYTES - 1));
                if (can_load) begin
                    if (gen_done) begin cnt_n = '0; state_n = ST_IDLE; end
                    else cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
        load   = gen_vld & can_load;
        crc_en = load & gen_crc & ~abort;
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state               <= ST_IDLE;
            cnt                 <= '0;
            idx                 <= '0;
            busy                <= 1'b0;
            out_vld             <= 1'b0;
            encode_fifo_wr_data <= 8'h00;
            encode_fifo_wr_mark <= 1'b0;
            encode_fifo_wr_done <= 1'b0;
        end else if (abort) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            idx     <= '0;
            busy    <= 1'b0;
            out_vld <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            if (start_ok)
                busy <= 1'b1;
            else if (encode_fifo_we && encode_fifo_wr_done)
                busy <= 1'b0;
            if (load) begin
                out_vld             <= 1'b1;
                encode_fifo_wr_data <= gen_data;
                encode_fifo_wr_mark <= gen_mark;
                encode_fifo_wr_done <= gen_done;
            end else if (encode_fifo_we) begin
                out_vld <= 1'b0;
            end
        end
    end

`ifdef FMT_ID_FIELD_EN
    always_ff @(posedge clk) begin
        if (start_ok) begin
            id_q[0] <= id_cyl;
            id_q[1] <= id_head;
            id_q[2] <= id_sec;
            id_q[3] <= id_size;
        end
    end
`endif

endmodule
